// File: rtl/demux_pkg.sv
// demux_pkg: shared select type, select constants, output count and one-hot decode for demux_reg
package demux_pkg;
  typedef logic [1:0] sel_t;
  localparam sel_t SEL_0 = 2'd0;
  localparam sel_t SEL_1 = 2'd1;
  localparam sel_t SEL_2 = 2'd2;
  localparam sel_t SEL_INVALID = 2'd3;
  localparam int N_OUT = 3;
  function automatic logic [2:0] onehot3(sel_t s);
    return s == SEL_0 ? 3'b001 : s == SEL_1 ? 3'b010 : s == SEL_2 ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/demux_ptr.sv
// demux_ptr: mod-3 round-robin pointer; clk, rst (sync, active-high), adv steps 0->1->2->0, ptr is the current value
module demux_ptr
  import demux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output sel_t ptr
);
  sel_t ptr_q, ptr_d;
  always_comb ptr_d = adv ? (ptr_q == SEL_2 ? SEL_0 : ptr_q + 2'd1) : ptr_q;
  always_ff @(posedge clk) ptr_q <= rst ? SEL_0 : ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-3 demux; in clk rst idata sel le auto clr_err, out odata0-2 ostb ptr err (+err_cnt when DEMUX_REG_ERRCNT_EN)
module demux_reg
  import demux_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] idata,
  input  logic [1:0]   sel,
  input  logic         le,
  input  logic         auto,
  input  logic         clr_err,
  output logic [W-1:0] odata0,
  output logic [W-1:0] odata1,
  output logic [W-1:0] odata2,
  output logic [2:0]   ostb,
  output logic [1:0]   ptr,
  output logic         err
`ifdef DEMUX_REG_ERRCNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);
  logic [W-1:0] od_q [N_OUT];
  logic [W-1:0] od_d [N_OUT];
  logic [2:0] ostb_q, ostb_d;
  logic err_q, err_d;
  sel_t ptr_w, tgt;
  logic wr, rej;
  assign tgt = auto ? ptr_w : sel;
  assign wr = le && tgt != SEL_INVALID;
  assign rej = le && !auto && sel == SEL_INVALID;
  demux_ptr u_ptr (.clk(clk), .rst(rst), .adv(wr && auto), .ptr(ptr_w));
  always_comb begin
    for (int i = 0; i < N_OUT; i++) od_d[i] = (wr && tgt == sel_t'(i)) ? idata : od_q[i];
    ostb_d = wr ? onehot3(tgt) : 3'b000;
    err_d = rej || (err_q && !clr_err);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      od_q <= '{default: '0};
      ostb_q <= 3'b000;
      err_q <= 1'b0;
    end else begin
      od_q <= od_d;
      ostb_q <= ostb_d;
      err_q <= err_d;
    end
  end
  assign odata0 = od_q[0];
  assign odata1 = od_q[1];
  assign odata2 = od_q[2];
  assign ostb = ostb_q;
  assign ptr = ptr_w;
  assign err = err_q;
`ifdef DEMUX_REG_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = rej ? (clr_err ? 8'd1 : cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1) : (clr_err ? 8'd0 : cnt_q);
  always_ff @(posedge clk) cnt_q <= rst ? 8'd0 : cnt_d;
  assign err_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux_reg.sv
// tb_demux_reg: randomized and directed check of demux_reg against a behavioural model
module tb_demux_reg;
  logic clk = 0, rst = 0, le = 0, auto = 0, clr_err = 0;
  logic [1:0] idata = 0, sel = 0;
  logic [1:0] odata0, odata1, odata2, ptr;
  logic [2:0] ostb;
  logic err;
  int n_cmp = 0, n_bad = 0;
  logic [1:0] m_od [3];
  logic [2:0] m_ostb;
  int m_ptr;
  logic m_err, started = 0;
`ifdef DEMUX_REG_ERRCNT_EN
  logic [7:0] err_cnt;
  int m_cnt;
`endif
  demux_reg #(.W(2)) dut (
    .clk(clk), .rst(rst), .idata(idata), .sel(sel), .le(le), .auto(auto), .clr_err(clr_err),
    .odata0(odata0), .odata1(odata1), .odata2(odata2), .ostb(ostb), .ptr(ptr), .err(err)
`ifdef DEMUX_REG_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    int t;
    if (rst) begin
      started = 1;
      m_od = '{0, 0, 0};
      m_ostb = 0;
      m_ptr = 0;
      m_err = 0;
`ifdef DEMUX_REG_ERRCNT_EN
      m_cnt = 0;
`endif
    end else begin
      t = auto ? m_ptr : int'(sel);
      m_ostb = 0;
      if (le && t < 3) begin
        m_od[t] = idata;
        m_ostb = 3'(1 << t);
        if (auto) m_ptr = (m_ptr + 1) % 3;
      end
      if (le && !auto && sel == 3) m_err = 1;
      else if (clr_err) m_err = 0;
`ifdef DEMUX_REG_ERRCNT_EN
      if (le && !auto && sel == 3) m_cnt = clr_err ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
      else if (clr_err) m_cnt = 0;
`endif
    end
    #1;
    if (started) begin
      chk("model_odata0", 8'(odata0), 8'(m_od[0]));
      chk("model_odata1", 8'(odata1), 8'(m_od[1]));
      chk("model_odata2", 8'(odata2), 8'(m_od[2]));
      chk("model_ostb", 8'(ostb), 8'(m_ostb));
      chk("model_ptr", 8'(ptr), 8'(m_ptr));
      chk("model_err", 8'(err), 8'(m_err));
`ifdef DEMUX_REG_ERRCNT_EN
      chk("model_err_cnt", err_cnt, 8'(m_cnt));
`endif
    end
  end
  task automatic cyc(input logic r, input logic l, input logic a, input logic c, input logic [1:0] s, input logic [1:0] d);
    rst = r; le = l; auto = a; clr_err = c; sel = s; idata = d;
    @(posedge clk);
    #2;
  endtask
  task automatic chk_all(input string nm, input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2,
                         input logic [2:0] st, input logic [1:0] p, input logic e);
    chk({nm, "_odata0"}, 8'(odata0), 8'(o0));
    chk({nm, "_odata1"}, 8'(odata1), 8'(o1));
    chk({nm, "_odata2"}, 8'(odata2), 8'(o2));
    chk({nm, "_ostb"}, 8'(ostb), 8'(st));
    chk({nm, "_ptr"}, 8'(ptr), 8'(p));
    chk({nm, "_err"}, 8'(err), 8'(e));
  endtask
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_all("reset", 0, 0, 0, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 3);
    chk_all("idle", 0, 0, 0, 3'b000, 0, 0);
    cyc(0, 1, 0, 0, 0, 1);
    chk_all("wr0", 1, 0, 0, 3'b001, 0, 0);
    cyc(0, 1, 0, 0, 1, 2);
    chk_all("wr1", 1, 2, 0, 3'b010, 0, 0);
    cyc(0, 1, 0, 0, 2, 3);
    chk_all("wr2", 1, 2, 3, 3'b100, 0, 0);
    cyc(0, 1, 0, 0, 3, 0);
    chk_all("invalid", 1, 2, 3, 3'b000, 0, 1);
    cyc(0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 3, 0);
    chk("err_sticky", 8'(err), 8'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("err_clear", 8'(err), 8'd0);
    cyc(0, 1, 0, 1, 3, 0);
    chk_all("clr_and_set", 1, 2, 3, 3'b000, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("err_clear2", 8'(err), 8'd0);
    cyc(0, 1, 1, 0, 3, 0);
    chk_all("rr0", 0, 2, 3, 3'b001, 1, 0);
    cyc(0, 1, 1, 0, 3, 1);
    chk_all("rr1", 0, 1, 3, 3'b010, 2, 0);
    cyc(0, 1, 1, 0, 3, 2);
    chk_all("rr2", 0, 1, 2, 3'b100, 0, 0);
    cyc(0, 1, 1, 0, 3, 3);
    chk_all("rr3", 3, 1, 2, 3'b001, 1, 0);
    cyc(0, 1, 0, 0, 2, 0);
    chk_all("hold", 3, 1, 0, 3'b100, 1, 0);
    cyc(0, 1, 1, 0, 2, 3);
    chk_all("resume", 3, 3, 0, 3'b010, 2, 0);
    cyc(1, 1, 0, 0, 1, 3);
    chk_all("rst_mid", 0, 0, 0, 3'b000, 0, 0);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, 2'($urandom), 2'($urandom));
`ifdef DEMUX_REG_ERRCNT_EN
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0, 3, 0);
    chk("err_cnt_sat", err_cnt, 8'd255);
    cyc(0, 1, 0, 1, 3, 0);
    chk("err_cnt_clr_set", err_cnt, 8'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("err_cnt_clr", err_cnt, 8'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
